// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one 1-bit full adder is stepped LSB-first over WIDTH cycles
// to form {cout,sum} = in_a + in_b + cin, with signed overflow reported as ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// Handshake: start is sampled only in IDLE, and that edge also captures the operands.
// busy is high for the WIDTH RUN cycles. done then pulses for one cycle, and sum,
// cout and ovf are valid from that cycle until the next done.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] shift_a, shift_b, res;
  logic             carry, msb_cin;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The only adder in the block; everything else is sequencing around it.
  full_adder u_fa (
    .a  (shift_a[0]),
    .b  (shift_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      res     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_a <= in_a;
            shift_b <= in_b;
            carry   <= cin;
            res     <= '0;
            msb_cin <= 1'b0;
            cnt     <= '0;
          end
        end
        RUN: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          carry   <= fa_c;
          res     <= {fa_s, res[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB, needed for ovf.
          if (cnt == CW'(WIDTH - 2)) msb_cin <= fa_c;
          if (last_bit) begin
            sum  <= {fa_s, res[WIDTH-1:1]};
            cout <= fa_c;
            ovf  <= msb_cin ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl. The reference model uses integer arithmetic.
// A separate monitor checks the result values, done timing, busy and held outputs.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic         start;
  logic [W-1:0] in_a, in_b;
  logic         cin;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .in_a      (in_a),
    .in_b      (in_b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int free_at = 0;
  int last_k  = -100;
  int n_acc   = 0;

  // Each entry is {ovf, cout, sum}. cyc_q holds the cycle in which done must appear.
  logic [W+1:0] exp_q[$];
  int           cyc_q[$];
  logic [W-1:0] m_sum;
  logic         m_cout, m_ovf;

  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    int u, sa, sb, s;
    logic [W+1:0] r;
    u  = int'(a) + int'(b) + int'(c);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb + int'(c);
    r[W-1:0] = u[W-1:0];
    r[W]     = u[W];
    r[W+1]   = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    cyc_q.delete();
    last_k  = -100;
    free_at = 0;
    m_sum   = '0;
    m_cout  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // ---- acceptance model: a start is taken only when no operation is in flight ----
  initial forever begin
    @(posedge sys_clk);
    cyc++;
    if (sys_rst_n === 1'b1 && start === 1'b1 && cyc >= free_at) begin
      exp_q.push_back(ref_add(in_a, in_b, cin));
      cyc_q.push_back(cyc + W);
      last_k  = cyc;
      free_at = cyc + W + 2;
      n_acc++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    logic [W+1:0] e;
    int           c;
    @(negedge sys_clk);
    check("busy", 32'(busy), 32'(cyc >= last_k && cyc <= last_k + W - 1));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(c));
        check("sum",  32'(sum),  32'(e[W-1:0]));
        check("cout", 32'(cout), 32'(e[W]));
        check("ovf",  32'(ovf),  32'(e[W+1]));
        m_sum  = e[W-1:0];
        m_cout = e[W];
        m_ovf  = e[W+1];
      end
    end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_done: got done=0 expected done=1 (cycle %0d)", cyc);
      void'(exp_q.pop_front());
      void'(cyc_q.pop_front());
    end
    check("sum_held",  32'(sum),  32'(m_sum));
    check("cout_held", 32'(cout), 32'(m_cout));
    check("ovf_held",  32'(ovf),  32'(m_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    cin   = c;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) @(negedge sys_clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
    @(negedge sys_clk);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    issue(a, b, c);
    drain(30);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sys_rst_n = 1'b0;
    start     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    cin       = 1'b0;
    clear_model();
    repeat (3) @(negedge sys_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    op(8'h00, 8'h00, 1'b1);
    op(8'hFF, 8'h01, 1'b0);
    op(8'h7F, 8'h01, 1'b0);
    op(8'h80, 8'h80, 1'b0);
    op(8'h12, 8'h34, 1'b1);

    // A start pulse with new operands in the middle of RUN must be ignored.
    issue(8'h3C, 8'h0F, 1'b0);
    repeat (3) @(negedge sys_clk);
    issue(8'h55, 8'h55, 1'b1);
    drain(30);

    // An asynchronous reset in the middle of RUN aborts the operation with no done pulse.
    issue(8'hA5, 8'h5A, 1'b1);
    repeat (4) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    clear_model();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (15) @(negedge sys_clk);

    // Hold start high and change the operands every cycle.
    n_acc = 0;
    start = 1'b1;
    for (int i = 0; i < 2100 && n_acc < 200; i++) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      cin  = 1'($urandom_range(0, 1));
      @(negedge sys_clk);
    end
    start = 1'b0;
    check("held_accepts", 32'(n_acc >= 200), 32'd1);
    drain(30);

    // Single-cycle start pulses at random gaps, some of them landing during RUN or DONE.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge sys_clk);
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
